// File: rtl/shift_norm_seq.sv
// shift_norm_seq: iterative normalizer, the companion of the barrel shifter.
// Derives the left-shift count that normalizes an operand (leading-one for
// unsigned, redundant-sign-bit count for signed) with a binary search of one
// stage per cycle (16, 8, 4, 2, 1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   in_data, in_signed    operand and signed/unsigned mode select
//   out_valid / out_ready result handshake (valid only while done)
//   out_data              normalized operand (in_data << out_count)
//   out_count             shift amount applied (32 for unsigned zero)
//   out_zero              operand had no significant bit
module shift_norm_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] count;
    logic [2:0]       stage;
    logic             sgn;
    logic             zero;

    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] sh_u;
    logic [CNT_W-1:0] sh_s;
    logic [WIDTH-1:0] top_u;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] mask_s;
    logic             hit;
    logic             accept;
    logic             in_zero;

    // in_ready is gated by rst_n so it reads 0 while reset is held even
    // though the state register already sits in IDLE.
    assign in_ready = (state == IDLE) && rst_n;
    assign accept   = in_ready && in_valid;
    assign in_zero  = (in_data == '0) || (in_signed && (in_data == '1));

    // Stage test: unsigned looks at the top n bits, signed at the top n+1
    // bits (all zero or all one means n redundant sign bits).
    always_comb begin
        n      = CNT_W'(1) << stage;
        sh_u   = CNT_W'(WIDTH) - n;
        sh_s   = CNT_W'(WIDTH - 1) - n;
        top_u  = work >> sh_u;
        top_s  = work >> sh_s;
        mask_s = {WIDTH{1'b1}} >> sh_s;
        if (sgn) begin
            hit = (top_s == '0) || (top_s == mask_s);
        end else begin
            hit = (top_u == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)        state_next = STEP;
            STEP: if (stage == 3'd0) state_next = DONE;
            DONE: if (out_ready)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            count <= '0;
            stage <= '0;
            sgn   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                work  <= in_data;
                sgn   <= in_signed;
                zero  <= in_zero;
                count <= '0;
                stage <= 3'd4;
            end else if (state == STEP) begin
                if (hit) begin
                    work  <= work << n;
                    count <= count + n;
                end
                if (stage != 3'd0) begin
                    stage <= stage - 3'd1;
                end
            end
        end
    end

    always_comb begin
        out_valid = (state == DONE);
        out_data  = '0;
        out_count = '0;
        out_zero  = 1'b0;
        if (state == DONE) begin
            out_data  = work;
            out_zero  = zero;
            out_count = (!sgn && zero) ? CNT_W'(WIDTH) : count;
        end
    end

endmodule

// File: tb/tb_shift_norm_seq.sv
// Directed self-checking bench for shift_norm_seq.
module tb_shift_norm_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_count;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    shift_norm_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer an operand, wait for the accept edge, then count edges until
    // out_valid. Returns 99 for latency if either wait runs out.
    task automatic start_op(input logic [31:0] d, input logic s, output int lat);
        int w;
        in_data  = d;
        in_signed = s;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            lat = 99;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic pop;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b exp 0", out_valid); end
        checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL idle_out_count got %0d exp 0", out_count); end
    endtask

    task automatic test_unsigned;
        int lat;
        start_op(32'h0001_0000, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL u10000_latency got %0d exp 5", lat); end
        checks++; if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL u10000_data got %h exp 80000000", out_data); end
        checks++; if (out_count !== 6'd15) begin errors++; $display("FAIL u10000_count got %0d exp 15", out_count); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL u10000_zero got %b exp 0", out_zero); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL u10000_in_ready got %b exp 0", in_ready); end
        pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL u10000_pop_valid got %b exp 0", out_valid); end

        start_op(32'h0000_0000, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL u0_latency got %0d exp 5", lat); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL u0_data got %h exp 0", out_data); end
        checks++; if (out_count !== 6'd32) begin errors++; $display("FAIL u0_count got %0d exp 32", out_count); end
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL u0_zero got %b exp 1", out_zero); end
        pop();
    endtask

    task automatic test_signed;
        logic [31:0] vin  [3];
        logic [31:0] vdat [3];
        logic [5:0]  vcnt [3];
        logic        vz   [3];
        int lat;
        vin[0] = 32'hFFFF_8000; vdat[0] = 32'h8000_0000; vcnt[0] = 6'd16; vz[0] = 1'b0;
        vin[1] = 32'h0000_0001; vdat[1] = 32'h4000_0000; vcnt[1] = 6'd30; vz[1] = 1'b0;
        vin[2] = 32'hFFFF_FFFF; vdat[2] = 32'h8000_0000; vcnt[2] = 6'd31; vz[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(vin[i], 1'b1, lat);
            checks++; if (lat !== 5) begin errors++; $display("FAIL s%0d_latency got %0d exp 5", i, lat); end
            checks++; if (out_data !== vdat[i]) begin errors++; $display("FAIL s%0d_data got %h exp %h", i, out_data, vdat[i]); end
            checks++; if (out_count !== vcnt[i]) begin errors++; $display("FAIL s%0d_count got %0d exp %0d", i, out_count, vcnt[i]); end
            checks++; if (out_zero !== vz[i]) begin errors++; $display("FAIL s%0d_zero got %b exp %b", i, out_zero, vz[i]); end
            pop();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int w;
        start_op(32'h0000_F000, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency got %0d exp 5", lat); end
        // next operand offered and held while the result is stalled
        in_data   = 32'h4000_0000;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'hF000_0000 || out_count !== 6'd16) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b r=%b d=%h c=%0d exp v=1 r=0 d=f0000000 c=16",
                         c, out_valid, in_ready, out_data, out_count);
            end
        end
        pop();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after_pop got %b exp 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accepted got in_ready %b exp 0", in_ready); end
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checks++; if (w !== 5) begin errors++; $display("FAIL bp_next_latency got %0d exp 5", w); end
        checks++; if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL bp_next_data got %h exp 80000000", out_data); end
        checks++; if (out_count !== 6'd1) begin errors++; $display("FAIL bp_next_count got %0d exp 1", out_count); end
        pop();
    endtask

    task automatic test_reset_mid_op;
        int lat;
        in_data   = 32'h0000_0001;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;   // accept edge (block is idle)
        in_valid = 1'b0;
        @(posedge clk); #1;   // stage 4 done
        @(posedge clk); #1;   // stage 3 done, stage 2 pending
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0 || out_count !== 6'd0 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_outputs got d=%h c=%0d z=%b exp 0", out_data, out_count, out_zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_recover_ready got %b exp 1", in_ready); end
        start_op(32'h4000_0000, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL mid_rst_latency got %0d exp 5", lat); end
        checks++; if (out_count !== 6'd1) begin errors++; $display("FAIL mid_rst_count got %0d exp 1", out_count); end
        checks++; if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL mid_rst_data got %h exp 80000000", out_data); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL mid_rst_zero got %b exp 0", out_zero); end
        pop();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/shift_norm_seq.md
Name: shift_norm_seq

Overview:
- Iterative normalizer for the functional unit. It is the inverse companion of the combinational barrel shifter: the shifter applies a given shift amount, and this block derives the shift amount.
- Finds the left-shift count that normalizes an operand: leading-one position for unsigned, redundant-sign-bit count for signed. Returns the normalized value and the count.
- Binary search, one stage per cycle (16, 8, 4, 2, 1), with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand width; must be 32 (stage schedule fixed at 16/8/4/2/1).
- CNT_W, 6, width of out_count; holds 0..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept an operand
- in_data  input  WIDTH  operand
- in_signed  input  1  1 = signed (sign-bit) normalization; 0 = unsigned (leading-one) normalization
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  normalized operand (in_data << out_count)
- out_count  output  CNT_W  left-shift amount applied
- out_zero  output  1  operand had no significant bit (unsigned 0; signed all-0 or all-1)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n = 0: state = IDLE; in_ready = 0; out_valid = 0; out_data = 0; out_count = 0; out_zero = 0; internal registers = 0. in_ready rises in the first cycle after rst_n deasserts.
- States: IDLE, STEP, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE. No overlap of operations.
- Accept: at the edge where state = IDLE and in_valid = 1:
  - Latch in_data into the work register and latch in_signed.
  - Clear the count and set the stage index to 4.
  - Go to STEP.
  - Zero detect at the same edge: unsigned and in_data = 0, or signed and in_data all-0 or all-1, sets a zero flag.
- STEP: one stage per edge, stage s = 4 down to 0, n = 2^s.
  - Unsigned: if work[31:32-n] are all 0, then work <= work << n and count += n.
  - Signed: if work[31:31-n] (n+1 bits) are all equal, then work <= work << n and count += n.
  - After stage 0: go to DONE.
- DONE is entered at the 5th edge after the accept edge. out_valid is first visible in the following cycle.
- DONE outputs:
  - out_data = work. out_zero = zero flag.
  - out_count = 32 if unsigned and zero flag is set; otherwise the accumulated count.
  - Results:
    - Unsigned nonzero: count 0..31, out_data[31] = 1.
    - Unsigned zero: out_data = 0.
    - Signed: count 0..31; out_data[31] != out_data[30] unless out_zero.
    - Signed all-1: out_data = 0x80000000, count 31.
    - Signed all-0: out_data = 0, count 31.
- Hold: out_data, out_count and out_zero are stable and out_valid stays 1 until out_ready = 1. On that edge go to IDLE and clear out_valid.
- in_valid while not IDLE is ignored; the source must hold it. out_ready in IDLE or STEP is ignored.
- Latency: accept edge to DONE edge is 5 cycles. Minimum accept-to-accept interval is 7 cycles when out_ready is held at 1.
- An rst_n assertion at any point, including STEP or DONE, aborts immediately: the result is discarded and all outputs return to reset values.
- Purely unsigned arithmetic on count; no saturation beyond the rules above.

Test Plan:
- Reset then idle: in_ready = 1 the cycle after rst_n deasserts; out_valid = 0; out_count = 0.
- Unsigned 0x00010000 -> out_data 0x80000000, out_count 15, out_zero 0. out_valid exactly 5 edges after the accept edge.
- Unsigned 0x00000000 -> out_data 0, out_count 32, out_zero 1.
- Signed cases:
  - 0xFFFF8000 -> out_data 0x80000000, out_count 16, out_zero 0.
  - 0x00000001 -> out_data 0x40000000, out_count 30.
  - 0xFFFFFFFF -> out_data 0x80000000, out_count 31, out_zero 1.
- Backpressure: unsigned 0x0000F000, out_ready = 0 for 10 cycles, in_valid held with a new operand.
  - Outputs must stay at out_data 0xF0000000, count 16, out_valid 1, in_ready 0.
  - After out_ready pulses: in_ready = 1 the next cycle, then the new operand is accepted.
- Reset mid-operation: assert rst_n = 0 during stage 2 of STEP.
  - Outputs go to reset values immediately.
  - After release, 0x40000000 unsigned yields count 1 with no residue from the aborted operand.
